// File: rtl/cv32e40p_mult_tmr_ctrl.sv
// Fault-management controller for the triplicated cv32e40p multiplier.
// Votes the three replica outputs, attributes disagreements to replicas,
// keeps saturating per-replica fault counters with periodic decay, retires
// a replica that crosses the fault threshold (TMR -> DMR) and requests a
// re-issue of the held operation when a mismatch cannot be corrected.
module cv32e40p_mult_tmr_ctrl #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FAIL_THRESH  = 8,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned DECAY_PERIOD = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [2:0]           rep_ready_i,
  input  logic [95:0]          rep_result_i,
  output logic [31:0]          result_o,
  output logic                 ready_o,
  output logic                 retry_o,
  output logic [2:0]           replica_en_o,
  output logic [3*CNT_W-1:0]   fault_cnt_o,
  output logic                 degraded_o,
  output logic                 fatal_o,
  output logic                 err_irq_o
);

  localparam int unsigned RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned DC_W = (DECAY_PERIOD < 2) ? 1 : $clog2(DECAY_PERIOD);

  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [RC_W-1:0]  RETRY_LAST = RC_W'(MAX_RETRY);
  localparam logic [RC_W-1:0]  RC_ONE     = RC_W'(1);
  localparam logic [DC_W-1:0]  DECAY_LAST = DC_W'(DECAY_PERIOD - 1);
  localparam logic [DC_W-1:0]  DC_ONE     = DC_W'(1);

  localparam logic [1:0] S_TMR   = 2'd0;
  localparam logic [1:0] S_DMR   = 2'd1;
  localparam logic [1:0] S_RETRY = 2'd2;
  localparam logic [1:0] S_FATAL = 2'd3;

  // Bitwise 2-of-3 majority.
  function automatic logic [31:0] maj32(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Saturating increment of a fault counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  // State
  logic [1:0]             state_q, state_d;
  logic                   origin_q, origin_d;       // 1: RETRY was entered from DMR
  logic [2:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]             rep_en_q, rep_en_d;
  logic [RC_W-1:0]        retry_cnt_q, retry_cnt_d;
  logic [DC_W-1:0]        decay_cnt_q, decay_cnt_d;
  logic                   retry_q, retry_d;
  logic                   err_irq_q, err_irq_d;
  logic                   degraded_q, degraded_d;
  logic                   fatal_q, fatal_d;

  // Datapath decode
  logic [2:0][31:0] res_s;
  logic [31:0]      vote_res_s;
  logic             vote_rdy_s;
  logic [2:0]       flag_s;
  logic [1:0]       n_flag_s;
  logic [31:0]      res_a_s, res_b_s;
  logic             rdy_a_s, rdy_b_s;
  logic             tmr_check_s, tmr_clean_s, tmr_corr_s, tmr_unc_s;
  logic             dmr_check_s, dmr_mis_s, dmr_clean_s;
  logic             clean_s, mis_s, pass_s;
  logic             dmr_hit_s;

  assign res_s      = rep_result_i;
  assign vote_res_s = maj32(res_s[0], res_s[1], res_s[2]);
  assign vote_rdy_s = (rep_ready_i[0] & rep_ready_i[1]) | (rep_ready_i[0] & rep_ready_i[2]) |
                      (rep_ready_i[1] & rep_ready_i[2]);

  // Flag every replica whose result or ready disagrees with the vote
  always_comb begin
    flag_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      flag_s[i] = (res_s[i] != vote_res_s) || (rep_ready_i[i] != vote_rdy_s);
    end
    n_flag_s = {1'b0, flag_s[0]} + {1'b0, flag_s[1]} + {1'b0, flag_s[2]};
  end

  // Select the healthy pair (a < b); a is also the lowest enabled replica
  always_comb begin
    case (rep_en_q)
      3'b110: begin
        res_a_s = res_s[1]; rdy_a_s = rep_ready_i[1];
        res_b_s = res_s[2]; rdy_b_s = rep_ready_i[2];
      end
      3'b101: begin
        res_a_s = res_s[0]; rdy_a_s = rep_ready_i[0];
        res_b_s = res_s[2]; rdy_b_s = rep_ready_i[2];
      end
      default: begin
        res_a_s = res_s[0]; rdy_a_s = rep_ready_i[0];
        res_b_s = res_s[1]; rdy_b_s = rep_ready_i[1];
      end
    endcase
  end

  assign tmr_check_s = enable_i & vote_rdy_s;
  assign tmr_clean_s = tmr_check_s & (n_flag_s == 2'd0);
  assign tmr_corr_s  = tmr_check_s & (n_flag_s == 2'd1);
  assign tmr_unc_s   = tmr_check_s & (n_flag_s >= 2'd2);

  // A ready disagreement between the pair is itself a check-worthy mismatch
  assign dmr_check_s = enable_i & (rdy_a_s | rdy_b_s);
  assign dmr_mis_s   = dmr_check_s & ((res_a_s != res_b_s) | (rdy_a_s != rdy_b_s));
  assign dmr_clean_s = dmr_check_s & ~dmr_mis_s;

  // Classify this cycle's check in the active mode; no checks in RETRY/FATAL
  always_comb begin
    case (state_q)
      S_TMR: begin
        clean_s = tmr_clean_s;
        mis_s   = tmr_corr_s | tmr_unc_s;
        pass_s  = tmr_clean_s | tmr_corr_s;
      end
      S_DMR: begin
        clean_s = dmr_clean_s;
        mis_s   = dmr_mis_s;
        pass_s  = dmr_clean_s;
      end
      default: begin
        clean_s = 1'b0;
        mis_s   = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // Result and ready towards EX, combinational from the replica outputs
  always_comb begin
    case (state_q)
      S_TMR: begin
        result_o = vote_res_s;
        ready_o  = vote_rdy_s & ~tmr_unc_s;
      end
      S_DMR: begin
        result_o = res_a_s;
        ready_o  = rdy_a_s & rdy_b_s & (res_a_s == res_b_s);
      end
      S_RETRY: begin
        result_o = origin_q ? res_a_s : vote_res_s;
        ready_o  = 1'b0;
      end
      S_FATAL: begin
        result_o = res_a_s;
        ready_o  = 1'b0;
      end
      default: begin
        result_o = res_a_s;
        ready_o  = 1'b0;
      end
    endcase
  end

  // A DMR mismatch pushes a second replica over the threshold
  always_comb begin
    dmr_hit_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dmr_hit_s = dmr_hit_s | (rep_en_q[i] & (sat_inc(cnt_q[i]) >= THRESH));
    end
  end

  // Next-state: mode transitions, fault counting, retry and decay bookkeeping
  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    cnt_d       = cnt_q;
    rep_en_d    = rep_en_q;
    retry_cnt_d = pass_s ? '0 : retry_cnt_q;
    decay_cnt_d = decay_cnt_q;
    err_irq_d   = mis_s;

    case (state_q)
      S_TMR: begin
        for (int i = 0; i < 3; i++) begin
          if (tmr_corr_s && flag_s[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (sat_inc(cnt_q[i]) >= THRESH) begin
              rep_en_d[i] = 1'b0;
              state_d     = S_DMR;
            end else begin
              rep_en_d[i] = rep_en_q[i];
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        if (tmr_unc_s) begin
          if (retry_cnt_q == RETRY_LAST) begin
            state_d = S_FATAL;
          end else begin
            state_d     = S_RETRY;
            origin_d    = 1'b0;
            retry_cnt_d = retry_cnt_q + RC_ONE;
          end
        end else begin
          origin_d = origin_q;
        end
      end
      S_DMR: begin
        if (dmr_mis_s) begin
          for (int i = 0; i < 3; i++) begin
            cnt_d[i] = rep_en_q[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
          end
          if (dmr_hit_s || (retry_cnt_q == RETRY_LAST)) begin
            state_d = S_FATAL;
          end else begin
            state_d     = S_RETRY;
            origin_d    = 1'b1;
            retry_cnt_d = retry_cnt_q + RC_ONE;
          end
        end else begin
          state_d = S_DMR;
        end
      end
      S_RETRY: state_d = origin_q ? S_DMR : S_TMR;
      S_FATAL: state_d = S_FATAL;
      default: state_d = S_FATAL;
    endcase

    // Decay: a clean check that completes the period relieves every enabled
    // nonzero counter; a mismatch landing there only restarts the period.
    if ((DECAY_PERIOD != 0) && (clean_s || mis_s)) begin
      if (decay_cnt_q == DECAY_LAST) begin
        decay_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
          cnt_d[i] = (clean_s && rep_en_q[i] && (cnt_q[i] != '0)) ? (cnt_q[i] - CNT_ONE)
                                                                  : cnt_d[i];
        end
      end else if (clean_s) begin
        decay_cnt_d = decay_cnt_q + DC_ONE;
      end else begin
        decay_cnt_d = decay_cnt_q;
      end
    end else begin
      decay_cnt_d = decay_cnt_q;
    end

    retry_d    = (state_d == S_RETRY) && (state_q != S_RETRY);
    degraded_d = (state_d == S_DMR) || ((state_d == S_RETRY) && origin_d);
    fatal_d    = (state_d == S_FATAL);
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_TMR;
      origin_q    <= 1'b0;
      cnt_q       <= '0;
      rep_en_q    <= 3'b111;
      retry_cnt_q <= '0;
      decay_cnt_q <= '0;
      retry_q     <= 1'b0;
      err_irq_q   <= 1'b0;
      degraded_q  <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      cnt_q       <= cnt_d;
      rep_en_q    <= rep_en_d;
      retry_cnt_q <= retry_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      retry_q     <= retry_d;
      err_irq_q   <= err_irq_d;
      degraded_q  <= degraded_d;
      fatal_q     <= fatal_d;
    end
  end

  assign retry_o      = retry_q;
  assign replica_en_o = rep_en_q;
  assign fault_cnt_o  = cnt_q;
  assign degraded_o   = degraded_q;
  assign fatal_o      = fatal_q;
  assign err_irq_o    = err_irq_q;

endmodule

// File: tb/tb_cv32e40p_mult_tmr_ctrl.sv
// Directed bench for cv32e40p_mult_tmr_ctrl (DECAY_PERIOD=4, FAIL_THRESH=8,
// MAX_RETRY=2). Each vector drives one cycle: combinational result/ready are
// compared before the edge, registered status after it.
module tb_cv32e40p_mult_tmr_ctrl;

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic [2:0]  rep_ready_i;
  logic [95:0] rep_result_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        retry_o;
  logic [2:0]  replica_en_o;
  logic [11:0] fault_cnt_o;
  logic        degraded_o;
  logic        fatal_o;
  logic        err_irq_o;

  cv32e40p_mult_tmr_ctrl #(
    .CNT_W(4), .FAIL_THRESH(8), .MAX_RETRY(2), .DECAY_PERIOD(4)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .rep_ready_i(rep_ready_i),
    .rep_result_i(rep_result_i), .result_o(result_o), .ready_o(ready_o),
    .retry_o(retry_o), .replica_en_o(replica_en_o), .fault_cnt_o(fault_cnt_o),
    .degraded_o(degraded_o), .fatal_o(fatal_o), .err_irq_o(err_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  rdy;
    logic [31:0] r0, r1, r2;
    logic [31:0] e_res;
    logic        e_rdy;
    logic        e_irq;
    logic        e_retry;
    logic [2:0]  e_en;
    logic [11:0] e_cnt;
    logic        e_deg;
    logic        e_fatal;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  task automatic add(input logic rst_v, input logic en, input logic [2:0] rdy,
                     input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] e_res, input logic e_rdy, input logic e_irq,
                     input logic e_retry, input logic [2:0] e_en, input logic [11:0] e_cnt,
                     input logic e_deg, input logic e_fatal);
    vec_t v;
    v.rst = rst_v; v.en = en; v.rdy = rdy; v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.e_res = e_res; v.e_rdy = e_rdy; v.e_irq = e_irq; v.e_retry = e_retry;
    v.e_en = e_en; v.e_cnt = e_cnt; v.e_deg = e_deg; v.e_fatal = e_fatal;
    tbl.push_back(v);
  endtask

  task automatic check_regs(input logic e_irq, input logic e_retry, input logic [2:0] e_en,
                            input logic [11:0] e_cnt, input logic e_deg, input logic e_fatal);
    chk("err_irq", {31'd0, err_irq_o}, {31'd0, e_irq});
    chk("retry", {31'd0, retry_o}, {31'd0, e_retry});
    chk("replica_en", {29'd0, replica_en_o}, {29'd0, e_en});
    chk("fault_cnt", {20'd0, fault_cnt_o}, {20'd0, e_cnt});
    chk("degraded", {31'd0, degraded_o}, {31'd0, e_deg});
    chk("fatal", {31'd0, fatal_o}, {31'd0, e_fatal});
  endtask

  task automatic drive(input logic en, input logic [2:0] rdy,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    enable_i     = en;
    rep_ready_i  = rdy;
    rep_result_i = {r2, r1, r0};
  endtask

  // Apply every queued vector for one cycle each, then empty the table.
  task automatic run_tbl();
    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      drive(tbl[k].en, tbl[k].rdy, tbl[k].r0, tbl[k].r1, tbl[k].r2);
      #2;
      chk("result", result_o, tbl[k].e_res);
      chk("ready", {31'd0, ready_o}, {31'd0, tbl[k].e_rdy});
      @(posedge clk);
      #1;
      check_regs(tbl[k].e_irq, tbl[k].e_retry, tbl[k].e_en, tbl[k].e_cnt,
                 tbl[k].e_deg, tbl[k].e_fatal);
      cur++;
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_regs(1'b0, 1'b0, 3'b111, 12'h000, 1'b0, 1'b0);

    // --- TMR voting, correction, retirement to DMR, DMR retry ---
    add(0, 1, 3'b111, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 1, 0, 0, 3'b111, 12'h000, 0, 0);
    add(0, 1, 3'b111, 32'h5, 32'hDEAD_0000, 32'h5, 32'h5, 1, 1, 0, 3'b111, 12'h010, 0, 0);
    add(0, 1, 3'b101, 32'h42, 32'h42, 32'h42, 32'h42, 1, 1, 0, 3'b111, 12'h020, 0, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h020, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      add(0, 1, 3'b111, 32'h7, 32'h7, 32'hFF, 32'h7, 1, 1, 0,
          (i == 8) ? 3'b011 : 3'b111, 12'h020 | 12'(i << 8), (i == 8), 0);
    end
    add(0, 1, 3'b111, 32'h10, 32'h11, 32'h10, 32'h10, 0, 1, 1, 3'b011, 12'h831, 1, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b011, 12'h831, 1, 0);
    add(0, 1, 3'b011, 32'h10, 32'h10, 32'hBAD, 32'h10, 1, 0, 0, 3'b011, 12'h831, 1, 0);
    add(0, 1, 3'b001, 32'h20, 32'h20, 32'h0, 32'h20, 0, 1, 1, 3'b011, 12'h842, 1, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b011, 12'h842, 1, 0);
    add(1, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    // --- decay with period 4 ---
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h2, 32'h2, 1, 1, 0, 3'b111, 12'h001, 0, 0);
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h2, 32'h2, 1, 1, 0, 3'b111, 12'h002, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 3'b111, 32'h6, 32'h6, 32'h6, 32'h6, 1, 0, 0, 3'b111,
          (i == 3) ? 12'h001 : 12'h002, 0, 0);
    end
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h2, 32'h2, 1, 1, 0, 3'b111, 12'h002, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 3'b111, 32'h6, 32'h6, 32'h6, 32'h6, 1, 0, 0, 3'b111, 12'h002, 0, 0);
    end
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h2, 32'h2, 1, 1, 0, 3'b111, 12'h003, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 3'b111, 32'h6, 32'h6, 32'h6, 32'h6, 1, 0, 0, 3'b111,
          (i == 3) ? 12'h002 : 12'h003, 0, 0);
    end
    add(1, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    // --- uncorrectable x3 with MAX_RETRY=2 -> FATAL ---
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h3, 32'h3, 0, 1, 1, 3'b111, 12'h000, 0, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h3, 32'h3, 0, 1, 1, 3'b111, 12'h000, 0, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h3, 32'h3, 0, 1, 0, 3'b111, 12'h000, 0, 1);
    add(0, 1, 3'b111, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, 0, 3'b111, 12'h000, 0, 1);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 1);
    add(1, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    add(0, 1, 3'b111, 32'h1, 32'h2, 32'h2, 32'h2, 1, 1, 0, 3'b111, 12'h001, 0, 0);
    run_tbl();

    // --- reset while in RETRY ---
    rst = 1'b0;
    drive(1'b1, 3'b111, 32'h1, 32'h2, 32'h3);
    @(posedge clk);
    #1;
    w = 0;
    while (!retry_o && w < 4) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("retry_before_rst", {31'd0, retry_o}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check_regs(1'b0, 1'b0, 3'b111, 12'h000, 1'b0, 1'b0);

    // Retry count must restart: two uncorrectables give two retries, not FATAL
    add(0, 1, 3'b111, 32'h4, 32'h5, 32'h6, 32'h4, 0, 1, 1, 3'b111, 12'h000, 0, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    add(0, 1, 3'b111, 32'h4, 32'h5, 32'h6, 32'h4, 0, 1, 1, 3'b111, 12'h000, 0, 0);
    add(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b111, 12'h000, 0, 0);
    add(0, 1, 3'b111, 32'h9, 32'h9, 32'h9, 32'h9, 1, 0, 0, 3'b111, 12'h000, 0, 0);
    run_tbl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
